// File: rtl/register_rx.sv
// Serial-to-parallel receiver: after a start strobe it samples WIDTH bits LSB first
// and presents the word with a valid/ack handshake. Optional parity: REGISTER_RX_PARITY_EN.
module register_rx #(
   parameter int WIDTH   = 4,
   parameter int COUNT_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               rx,
   input  logic               data_ack,
   output logic [WIDTH-1:0]   data,
   output logic               data_valid,
   output logic               busy,
   output logic [COUNT_W-1:0] count,
   output logic               overrun,
   output logic               parity_err
);

   // state   | meaning
   // S_IDLE  | waiting for start; rx ignored
   // S_SHIFT | sampling frame bits, one per edge
   typedef enum logic {S_IDLE, S_SHIFT} state_t;

`ifdef REGISTER_RX_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   state_t               state_q;
   logic [WIDTH-1:0]     shift_q, shift_d;
   logic [WIDTH-1:0]     data_q;
   logic [COUNT_W-1:0]   count_q;
   logic                 valid_q;
   logic                 overrun_q;
   logic                 last_bit;

   assign last_bit = (state_q == S_SHIFT) && (count_q == COUNT_W'(FRAME - 1));

   // The parity sample (count == WIDTH) matches no data index, so the word is left alone.
   always_comb begin
      shift_d = shift_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (count_q == COUNT_W'(i)) shift_d[i] = rx;
      end
   end

`ifdef REGISTER_RX_PARITY_EN
   logic perr_q;

   always_ff @(posedge clk) begin
      if (reset) perr_q <= 1'b0;
      else if (last_bit) perr_q <= (^shift_q) ^ rx;
   end

   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         data_q    <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (data_ack && valid_q) valid_q <= 1'b0;
         if (last_bit) begin
            data_q  <= shift_d;
            valid_q <= 1'b1;
            if (valid_q && !data_ack) overrun_q <= 1'b1;
         end
         // start wins over both a running frame and a completing one: that edge is a new E0
         if (start) begin
            state_q <= S_SHIFT;
            count_q <= '0;
            shift_q <= '0;
         end else if (state_q == S_SHIFT) begin
            if (last_bit) begin
               state_q <= S_IDLE;
               count_q <= '0;
            end else begin
               count_q <= count_q + COUNT_W'(1);
               shift_q <= shift_d;
            end
         end
      end
   end

   assign data       = data_q;
   assign data_valid = valid_q;
   assign busy       = (state_q == S_SHIFT);
   assign count      = count_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_register_rx.sv
// Scoreboard bench for register_rx: stimulus pushes expected words, a negedge monitor
// pops and compares whenever a new word appears on data/data_valid.
module tb_register_rx;

   localparam int WIDTH   = 4;
   localparam int COUNT_W = 3;
`ifdef REGISTER_RX_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic               rx = 1'b0;
   logic               data_ack = 1'b0;
   logic [WIDTH-1:0]   data;
   logic               data_valid;
   logic               busy;
   logic [COUNT_W-1:0] count;
   logic               overrun;
   logic               parity_err;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             ovr;
      logic             perr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   register_rx #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .rx(rx), .data_ack(data_ack),
      .data(data), .data_valid(data_valid), .busy(busy), .count(count),
      .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: a new word is presented when valid rises or data changes while valid.
   logic             pv = 1'b0;
   logic [WIDTH-1:0] pd = '0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset && data_valid === 1'b1 && (!pv || data !== pd)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", data, $time);
         end else begin
            e = exp_q.pop_front();
            chk("word_data", 32'(data), 32'(e.d));
            chk("word_overrun", 32'(overrun), 32'(e.ovr));
            chk("word_parity_err", 32'(parity_err), 32'(e.perr));
         end
      end
      pv = data_valid;
      pd = data;
   end

   task automatic push(input logic [WIDTH-1:0] d, input logic ovr, input logic perr);
      exp_t e;
      e.d = d; e.ovr = ovr; e.perr = perr;
      exp_q.push_back(e);
   endtask

   task automatic begin_frame();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Shift n bits of d (plus parity when enabled); ack/start optionally on the last edge.
   task automatic shift_bits(input logic [WIDTH-1:0] d, input int n, input bit ack_last,
                             input bit start_last, input bit bad_par);
      logic [NB-1:0] fb;
`ifdef REGISTER_RX_PARITY_EN
      fb = {(^d) ^ bad_par, d};
`else
      fb = d;
`endif
      for (int i = 0; i < n; i++) begin
         rx = fb[i];
         if (i == n - 1) begin
            data_ack = ack_last;
            start    = start_last;
         end
         @(posedge clk); #1;
      end
      data_ack = 1'b0;
      start    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] f1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", 32'(data), 0);
      chk("rst_valid", 32'(data_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_parity_err", 32'(parity_err), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Frame 1,0,1,0 -> 5 with count/busy tracked each edge
      f1 = 4'b0101;
      push(4'h5, 1'b0, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("e0_busy", 32'(busy), 1);
      chk("e0_count", 32'(count), 0);
      for (int i = 0; i < NB; i++) begin
         logic [NB-1:0] fb;
`ifdef REGISTER_RX_PARITY_EN
         fb = {^f1, f1};
`else
         fb = f1;
`endif
         rx = fb[i];
         @(posedge clk); #1;
         if (i < NB - 1) begin
            chk("mid_count", 32'(count), 32'(i + 1));
            chk("mid_busy", 32'(busy), 1);
            chk("mid_valid", 32'(data_valid), 0);
         end else begin
            chk("end_count", 32'(count), 0);
            chk("end_busy", 32'(busy), 0);
            chk("end_valid", 32'(data_valid), 1);
         end
      end

      // Unacked, second frame 1,1,0,0 -> 3 with overrun
      push(4'h3, 1'b1, 1'b0);
      begin_frame();
      shift_bits(4'b0011, NB, 1'b0, 1'b0, 1'b0);
      chk("ovr_sticky", 32'(overrun), 1);

      // Reset mid-frame discards everything
      begin_frame();
      shift_bits(4'b1111, 2, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mrst_data", 32'(data), 0);
      chk("mrst_valid", 32'(data_valid), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_count", 32'(count), 0);
      chk("mrst_overrun", 32'(overrun), 0);
      @(posedge clk); #1;

      // 0,0,0,1 -> 8 (ack while invalid is ignored)
      push(4'h8, 1'b0, 1'b0);
      begin_frame();
      shift_bits(4'b1000, NB, 1'b1, 1'b0, 1'b0);
      chk("ack_ignored_valid", 32'(data_valid), 1);

      // 1,1 then restart with 0,1,1,0 -> 6, acked on completion: no overrun
      push(4'h6, 1'b0, 1'b0);
      begin_frame();
      shift_bits(4'b1111, 2, 1'b0, 1'b0, 1'b0);
      begin_frame();
      shift_bits(4'b0110, NB, 1'b1, 1'b0, 1'b0);
      chk("ack_cmpl_overrun", 32'(overrun), 0);

      // Back-to-back 1 then 2, start on completion edge
      push(4'h1, 1'b0, 1'b0);
      push(4'h2, 1'b0, 1'b0);
      begin_frame();
      shift_bits(4'b0001, NB, 1'b1, 1'b1, 1'b0);
      chk("b2b_busy", 32'(busy), 1);
      chk("b2b_count", 32'(count), 0);
      shift_bits(4'b0010, NB, 1'b1, 1'b0, 1'b0);
      chk("b2b_overrun", 32'(overrun), 0);

      data_ack = 1'b1;
      @(posedge clk); #1;
      data_ack = 1'b0;
      chk("ack_clears_valid", 32'(data_valid), 0);
      chk("ack_keeps_data", 32'(data), 2);

`ifdef REGISTER_RX_PARITY_EN
      push(4'h5, 1'b0, 1'b0);
      begin_frame();
      shift_bits(4'b0101, NB, 1'b0, 1'b0, 1'b0);
      data_ack = 1'b1;
      @(posedge clk); #1;
      data_ack = 1'b0;
      push(4'h5, 1'b0, 1'b1);
      begin_frame();
      shift_bits(4'b0101, NB, 1'b0, 1'b0, 1'b1);
      chk("par_valid", 32'(data_valid), 1);
      chk("par_err", 32'(parity_err), 1);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
